// File: rtl/gbdmg_pkg.sv
// Shared constants for the DMG-style PSG channels: duty tables, default widths
// and frame-sequencer step masks used by the top level.
package gbdmg_pkg;

  localparam int FREQ_W_DEF = 11;
  localparam int VOL_W_DEF  = 4;
  localparam int LEN_W_DEF  = 6;

  // Bit n of each entry is the output at duty position n.
  localparam logic [7:0] DUTY_PAT [4] = '{8'b0000_0001, 8'b1000_0001,
                                          8'b1000_0111, 8'b0111_1110};

  // 512 Hz frame sequencer: which of the 8 steps clock each unit.
  localparam int         FS_STEPS       = 8;
  localparam logic [7:0] FS_LEN_STEPS   = 8'b0101_0101;
  localparam logic [7:0] FS_SWEEP_STEPS = 8'b0100_0100;
  localparam logic [7:0] FS_ENV_STEPS   = 8'b1000_0000;

  function automatic logic duty_bit(input logic [1:0] code, input logic [2:0] pos);
    return DUTY_PAT[code][pos];
  endfunction

endpackage

// File: rtl/gbdmg_env_unit.sv
// Volume envelope: trigger loads volume and period, each expiry steps the
// volume by one toward the direction's rail. Period 0 freezes the volume.
module gbdmg_env_unit
  import gbdmg_pkg::*;
#(
  parameter int VOL_W = VOL_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             trig_i,
  input  logic             tick_i,
  input  logic [VOL_W-1:0] vol_init_i,
  input  logic             dir_i,
  input  logic [2:0]       period_i,
  output logic [VOL_W-1:0] vol_o
);

  logic [2:0]       cnt_q, cnt_d;
  logic [VOL_W-1:0] vol_q, vol_d;

  always_comb begin
    cnt_d = cnt_q;
    vol_d = vol_q;
    if (trig_i) begin
      cnt_d = period_i;
      vol_d = vol_init_i;
    end else if (tick_i && period_i != 3'd0) begin
      // A counter left at 0 by a period-0 trigger expires on the first tick.
      if (cnt_q <= 3'd1) begin
        cnt_d = period_i;
        if (dir_i && vol_q != '1)
          vol_d = vol_q + VOL_W'(1);
        else if (!dir_i && vol_q != '0)
          vol_d = vol_q - VOL_W'(1);
      end else begin
        cnt_d = cnt_q - 3'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
      vol_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      vol_q <= vol_d;
    end
  end

  assign vol_o = vol_q;

endmodule

// File: rtl/gbdmg_tone_channel.sv
// DMG-style square channel: prescaled duty timer, envelope, length counter
// and optional frequency sweep with overflow kill.
module gbdmg_tone_channel
  import gbdmg_pkg::*;
#(
  parameter int FREQ_W   = FREQ_W_DEF,
  parameter int VOL_W    = VOL_W_DEF,
  parameter int LEN_W    = LEN_W_DEF,
  parameter int PRESCALE = 4,
  parameter int SWEEP_EN = 1
) (
  input  logic              in_clk,
  input  logic              in_rst_n,
  input  logic [FREQ_W-1:0] in_freq,
  input  logic [1:0]        in_duty,
  input  logic [VOL_W-1:0]  in_env_vol,
  input  logic              in_env_dir,
  input  logic [2:0]        in_env_period,
  input  logic [2:0]        in_sweep_period,
  input  logic              in_sweep_dir,
  input  logic [2:0]        in_sweep_shift,
  input  logic [LEN_W-1:0]  in_len,
  input  logic              in_len_wr,
  input  logic              in_len_en,
  input  logic              in_trigger,
  input  logic              in_tick_len,
  input  logic              in_tick_env,
  input  logic              in_tick_sweep,
  output logic              out_bit,
  output logic [VOL_W-1:0]  out_vol,
  output logic              out_active,
  output logic [FREQ_W-1:0] out_freq,
  output logic              out_freq_upd
);

  localparam int             PS_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [LEN_W:0] LEN_FULL = {1'b1, {LEN_W{1'b0}}};

  logic dac_en;
  assign dac_en = (in_env_vol != '0) || in_env_dir;

  logic [PS_W-1:0] ps_q;
  logic            ps_wrap;
  assign ps_wrap = (ps_q == PS_W'(PRESCALE - 1));

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) ps_q <= '0;
    else           ps_q <= ps_wrap ? '0 : ps_q + PS_W'(1);
  end

  logic [FREQ_W-1:0] sw_freq;
  logic              sw_kill;
  logic              sw_upd;

  generate
    if (SWEEP_EN != 0) begin : g_sweep
      logic [FREQ_W-1:0] sh_q, sh_d;
      logic [3:0]        scnt_q, scnt_d;
      logic              upd_q, upd_d;
      logic [FREQ_W-1:0] base, delta;
      logic [FREQ_W:0]   sum, diff;
      logic              ovf;

      // Trigger checks the freshly loaded frequency, not the old shadow.
      assign base  = in_trigger ? in_freq : sh_q;
      assign delta = base >> in_sweep_shift;
      assign sum   = {1'b0, base} + {1'b0, delta};
      assign diff  = {1'b0, base} - {1'b0, delta};
      assign ovf   = !in_sweep_dir && sum[FREQ_W];

      always_comb begin
        sh_d    = sh_q;
        scnt_d  = scnt_q;
        upd_d   = 1'b0;
        sw_kill = 1'b0;
        if (in_trigger) begin
          sh_d    = in_freq;
          scnt_d  = {1'b0, in_sweep_period};
          sw_kill = (in_sweep_shift != 3'd0) && ovf;
        end else if (in_tick_sweep) begin
          if (scnt_q <= 4'd1) begin
            scnt_d = (in_sweep_period == 3'd0) ? 4'd8 : {1'b0, in_sweep_period};
            if (in_sweep_period != 3'd0) begin
              if (ovf) begin
                sw_kill = 1'b1;
              end else if (in_sweep_shift != 3'd0) begin
                sh_d  = in_sweep_dir ? diff[FREQ_W-1:0] : sum[FREQ_W-1:0];
                upd_d = 1'b1;
              end
            end
          end else begin
            scnt_d = scnt_q - 4'd1;
          end
        end
      end

      always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
          sh_q   <= '0;
          scnt_q <= '0;
          upd_q  <= 1'b0;
        end else begin
          sh_q   <= sh_d;
          scnt_q <= scnt_d;
          upd_q  <= upd_d;
        end
      end

      assign sw_freq = sh_q;
      assign sw_upd  = upd_q;
    end else begin : g_no_sweep
      assign sw_freq = '0;
      assign sw_kill = 1'b0;
      assign sw_upd  = 1'b0;
    end
  endgenerate

  logic [FREQ_W-1:0] timer_freq;
  assign timer_freq = (SWEEP_EN != 0) ? sw_freq : in_freq;

  logic [FREQ_W-1:0] tmr_q, tmr_d;
  logic [2:0]        pos_q, pos_d;
  logic [LEN_W:0]    len_q, len_d;
  logic              len_expire;
  logic              active_q, active_d;
  logic              bit_q, bit_d;

  always_comb begin
    tmr_d = tmr_q;
    pos_d = pos_q;
    if (in_trigger) begin
      tmr_d = in_freq;
    end else if (ps_wrap) begin
      if (&tmr_q) begin
        tmr_d = timer_freq;
        pos_d = pos_q + 3'd1;
      end else begin
        tmr_d = tmr_q + FREQ_W'(1);
      end
    end
  end

  always_comb begin
    len_d      = len_q;
    len_expire = 1'b0;
    if (in_len_wr) begin
      len_d = LEN_FULL - {1'b0, in_len};
    end else if (in_trigger) begin
      if (len_q == '0) len_d = LEN_FULL;
    end else if (in_tick_len && in_len_en && len_q != '0) begin
      len_d      = len_q - (LEN_W+1)'(1);
      len_expire = (len_q == (LEN_W+1)'(1));
    end
  end

  always_comb begin
    active_d = active_q;
    if (!dac_en)                     active_d = 1'b0;
    else if (in_trigger)             active_d = !sw_kill;
    else if (len_expire || sw_kill)  active_d = 1'b0;
    bit_d = duty_bit(in_duty, pos_d) & active_d;
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      tmr_q    <= '0;
      pos_q    <= '0;
      len_q    <= '0;
      active_q <= 1'b0;
      bit_q    <= 1'b0;
    end else begin
      tmr_q    <= tmr_d;
      pos_q    <= pos_d;
      len_q    <= len_d;
      active_q <= active_d;
      bit_q    <= bit_d;
    end
  end

  gbdmg_env_unit #(.VOL_W(VOL_W)) u_env (
    .clk_i      (in_clk),
    .rst_n_i    (in_rst_n),
    .trig_i     (in_trigger),
    .tick_i     (in_tick_env),
    .vol_init_i (in_env_vol),
    .dir_i      (in_env_dir),
    .period_i   (in_env_period),
    .vol_o      (out_vol)
  );

  assign out_bit      = bit_q;
  assign out_active   = active_q;
  assign out_freq     = sw_freq;
  assign out_freq_upd = sw_upd;

endmodule

// File: tb/tb_gbdmg_tone_channel.sv
// Randomised and directed bench for gbdmg_tone_channel against an
// integer-arithmetic reference model of the channel's behaviour.
module tb_gbdmg_tone_channel;

  localparam int FREQ_W   = 11;
  localparam int VOL_W    = 4;
  localparam int LEN_W    = 6;
  localparam int PRESCALE = 4;
  localparam int FMAX     = (1 << FREQ_W) - 1;

  logic              in_clk = 1'b0;
  logic              in_rst_n;
  logic [FREQ_W-1:0] in_freq;
  logic [1:0]        in_duty;
  logic [VOL_W-1:0]  in_env_vol;
  logic              in_env_dir;
  logic [2:0]        in_env_period;
  logic [2:0]        in_sweep_period;
  logic              in_sweep_dir;
  logic [2:0]        in_sweep_shift;
  logic [LEN_W-1:0]  in_len;
  logic              in_len_wr, in_len_en, in_trigger;
  logic              in_tick_len, in_tick_env, in_tick_sweep;
  logic              out_bit;
  logic [VOL_W-1:0]  out_vol;
  logic              out_active;
  logic [FREQ_W-1:0] out_freq;
  logic              out_freq_upd;

  always #5 in_clk = ~in_clk;

  gbdmg_tone_channel #(
    .FREQ_W(FREQ_W), .VOL_W(VOL_W), .LEN_W(LEN_W), .PRESCALE(PRESCALE), .SWEEP_EN(1)
  ) dut (
    .in_clk(in_clk), .in_rst_n(in_rst_n), .in_freq(in_freq), .in_duty(in_duty),
    .in_env_vol(in_env_vol), .in_env_dir(in_env_dir), .in_env_period(in_env_period),
    .in_sweep_period(in_sweep_period), .in_sweep_dir(in_sweep_dir),
    .in_sweep_shift(in_sweep_shift), .in_len(in_len), .in_len_wr(in_len_wr),
    .in_len_en(in_len_en), .in_trigger(in_trigger), .in_tick_len(in_tick_len),
    .in_tick_env(in_tick_env), .in_tick_sweep(in_tick_sweep), .out_bit(out_bit),
    .out_vol(out_vol), .out_active(out_active), .out_freq(out_freq),
    .out_freq_upd(out_freq_upd)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: timer kept as "ticks left until the next duty step".
  int pat [4] = '{1, 129, 135, 126};
  int m_n, m_left, m_pos, m_vol, m_envc, m_len, m_sh, m_swc, m_act, m_bit, m_upd;

  task automatic model_reset();
    m_n = 0; m_left = FMAX + 1; m_pos = 0; m_vol = 0; m_envc = 0; m_len = 0;
    m_sh = 0; m_swc = 0; m_act = 0; m_bit = 0; m_upd = 0;
  endtask

  task automatic model_edge();
    int  f, sh, nf, fin;
    bit  dac, pst, expire, kill;
    dac = (in_env_vol != 0) || in_env_dir;
    pst = (m_n % PRESCALE) == PRESCALE - 1;
    m_n++;
    fin = int'(in_freq);
    if (in_trigger) m_left = FMAX + 1 - fin;
    else if (pst) begin
      if (m_left == 1) begin m_pos = (m_pos + 1) % 8; m_left = FMAX + 1 - m_sh; end
      else m_left--;
    end
    if (in_trigger) begin m_vol = int'(in_env_vol); m_envc = int'(in_env_period); end
    else if (in_tick_env && in_env_period != 0) begin
      if (m_envc <= 1) begin
        m_envc = int'(in_env_period);
        if (in_env_dir) m_vol = (m_vol < 15) ? m_vol + 1 : 15;
        else            m_vol = (m_vol > 0) ? m_vol - 1 : 0;
      end else m_envc--;
    end
    expire = 0;
    if (in_len_wr) m_len = 64 - int'(in_len);
    else if (in_trigger) begin if (m_len == 0) m_len = 64; end
    else if (in_tick_len && in_len_en && m_len > 0) begin
      m_len--; expire = (m_len == 0);
    end
    kill = 0; m_upd = 0;
    sh = int'(in_sweep_shift);
    if (in_trigger) begin
      m_sh = fin; m_swc = int'(in_sweep_period);
      if (sh != 0 && !in_sweep_dir && fin + (fin >> sh) > FMAX) kill = 1;
    end else if (in_tick_sweep) begin
      if (m_swc <= 1) begin
        m_swc = (in_sweep_period == 0) ? 8 : int'(in_sweep_period);
        if (in_sweep_period != 0) begin
          f  = m_sh;
          nf = in_sweep_dir ? f - (f >> sh) : f + (f >> sh);
          if (nf > FMAX) kill = 1;
          else if (sh != 0) begin m_sh = nf; m_upd = 1; end
        end
      end else m_swc--;
    end
    if (!dac) m_act = 0;
    else if (in_trigger) m_act = kill ? 0 : 1;
    else if (expire || kill) m_act = 0;
    m_bit = m_act & ((pat[in_duty] >> m_pos) & 1);
  endtask

  task automatic cycle();
    model_edge();
    @(posedge in_clk); #1;
    chk("bit",  32'(out_bit),      32'(m_bit));
    chk("vol",  32'(out_vol),      32'(m_vol));
    chk("act",  32'(out_active),   32'(m_act));
    chk("freq", 32'(out_freq),     32'(m_sh));
    chk("upd",  32'(out_freq_upd), 32'(m_upd));
    in_trigger = 0; in_len_wr = 0; in_tick_len = 0; in_tick_env = 0; in_tick_sweep = 0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_bit"},  32'(out_bit), 0);
    chk({tag, "_vol"},  32'(out_vol), 0);
    chk({tag, "_act"},  32'(out_active), 0);
    chk({tag, "_freq"}, 32'(out_freq), 0);
    chk({tag, "_upd"},  32'(out_freq_upd), 0);
  endtask

  task automatic set_regs(input int f, input int d, input int v, input int edir, input int ep,
                          input int sp, input int sdir, input int ssh);
    in_freq = FREQ_W'(f); in_duty = 2'(d); in_env_vol = VOL_W'(v); in_env_dir = 1'(edir);
    in_env_period = 3'(ep); in_sweep_period = 3'(sp); in_sweep_dir = 1'(sdir);
    in_sweep_shift = 3'(ssh);
  endtask

  task automatic do_reset();
    @(negedge in_clk); in_rst_n = 0; #1;
    check_zero("rst");
    model_reset();
    @(negedge in_clk); in_rst_n = 1;
  endtask

  initial begin
    in_rst_n = 0;
    set_regs(0, 0, 0, 0, 0, 0, 0, 0);
    in_len = 0; in_len_en = 0; in_len_wr = 0; in_trigger = 0;
    in_tick_len = 0; in_tick_env = 0; in_tick_sweep = 0;
    #3; check_zero("por");
    model_reset();
    @(negedge in_clk); in_rst_n = 1;

    // Duty 2 tone at 2 timer ticks per step.
    set_regs(12'h7FE, 2, 15, 0, 0, 0, 0, 0);
    in_trigger = 1; cycle();
    chk("tone_vol", 32'(out_vol), 15);
    chk("tone_act", 32'(out_active), 1);
    repeat (80) cycle();
    in_duty = 2'd3; repeat (20) cycle();

    // DAC off blocks trigger; dropping volume kills an active channel.
    do_reset();
    set_regs(12'h7F0, 1, 0, 0, 0, 0, 0, 0);
    in_trigger = 1; cycle();
    chk("dac_trig_act", 32'(out_active), 0);
    chk("dac_trig_bit", 32'(out_bit), 0);
    in_env_vol = 4'hF; in_trigger = 1; cycle();
    chk("dac_on_act", 32'(out_active), 1);
    in_env_vol = 4'h0; cycle();
    chk("dac_drop_act", 32'(out_active), 0);

    // Envelope down from 2, then period 0 holds.
    set_regs(12'h700, 0, 2, 0, 1, 0, 0, 0);
    in_trigger = 1; cycle();
    for (int i = 0; i < 4; i++) begin
      in_tick_env = 1; cycle();
      chk("env_step", 32'(out_vol), (i == 0) ? 1 : 0);
    end
    in_env_period = 0; in_trigger = 1; cycle();
    repeat (3) begin in_tick_env = 1; cycle(); chk("env_hold", 32'(out_vol), 2); end
    // Trigger beats a same-cycle envelope tick.
    set_regs(12'h700, 0, 5, 0, 1, 0, 0, 0);
    in_trigger = 1; in_tick_env = 1; cycle();
    chk("env_trig_tick", 32'(out_vol), 5);

    // Length 2 expires on the second tick; a write beats a same-cycle tick.
    in_len = 6'd62; in_len_wr = 1; cycle();
    in_len_en = 1; in_trigger = 1; cycle();
    in_tick_len = 1; cycle(); chk("len_tick1", 32'(out_active), 1);
    in_tick_len = 1; cycle(); chk("len_tick2", 32'(out_active), 0);
    in_trigger = 1; cycle();
    in_len_wr = 1; in_tick_len = 1; cycle(); chk("len_wr_tick", 32'(out_active), 1);
    in_tick_len = 1; cycle(); chk("len_after_wr1", 32'(out_active), 1);
    in_tick_len = 1; cycle(); chk("len_after_wr2", 32'(out_active), 0);
    in_len_en = 0;

    // Sweep add 0x400 -> 0x600, then overflow kill.
    set_regs(12'h400, 2, 15, 0, 0, 1, 0, 1);
    in_trigger = 1; in_tick_sweep = 1; cycle();
    chk("sw_trig_freq", 32'(out_freq), 12'h400);
    chk("sw_trig_upd", 32'(out_freq_upd), 0);
    in_tick_sweep = 1; cycle();
    chk("sw_freq1", 32'(out_freq), 12'h600);
    chk("sw_upd1", 32'(out_freq_upd), 1);
    chk("sw_act1", 32'(out_active), 1);
    cycle(); chk("sw_upd_pulse", 32'(out_freq_upd), 0);
    in_tick_sweep = 1; cycle();
    chk("sw_ovf_act", 32'(out_active), 0);
    chk("sw_ovf_freq", 32'(out_freq), 12'h600);

    // Mid-tone reset.
    set_regs(12'h7FC, 3, 9, 1, 2, 0, 0, 0);
    in_trigger = 1; cycle();
    repeat (13) cycle();
    do_reset();

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 29) == 0)
        set_regs(($urandom_range(0, 3) == 0) ? int'($urandom_range(0, FMAX))
                                              : int'($urandom_range(FMAX - 15, FMAX)),
                 int'($urandom_range(0, 3)),
                 ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 15)),
                 int'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 7)), int'($urandom_range(0, 1)),
                 int'($urandom_range(0, 7)));
      if ($urandom_range(0, 49) == 0) begin
        in_len = LEN_W'($urandom_range(40, 63)); in_len_wr = 1;
      end
      if ($urandom_range(0, 99) == 0) in_len_en = 1'($urandom_range(0, 1));
      in_duty       = ($urandom_range(0, 63) == 0) ? 2'($urandom_range(0, 3)) : in_duty;
      in_trigger    = ($urandom_range(0, 39) == 0);
      in_tick_len   = ($urandom_range(0, 7) == 0);
      in_tick_env   = ($urandom_range(0, 7) == 0);
      in_tick_sweep = ($urandom_range(0, 7) == 0);
      if (i == 1500) do_reset();
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
